// File: rtl/pdm_tx.sv
// pdm_tx: first-order sigma-delta PDM transmitter with its own bit clock.
// Ports:
//   clk, rst_n          - system clock, async active-low reset
//   enable              - block enable; low holds everything cleared
//   clk_div             - PDM clock half-period minus one, in clk cycles
//   osr                 - PDM bits per PCM sample (0 behaves as 1)
//   pcm_i, pcm_valid_i  - signed PCM sample and its valid
//   pcm_ready_o         - holding register can accept a sample
//   pdm_clk_o, pdm_o    - PDM bit clock and data (data changes as clock falls)
//   underrun_o          - sticky: a sample period started with no sample
//   busy_o              - a sample has been accepted since enable rose
module pdm_tx #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] clk_div,
   input  logic [DIV_W-1:0] osr,
   input  logic [WIDTH-1:0] pcm_i,
   input  logic             pcm_valid_i,
   output logic             pcm_ready_o,
   output logic             pdm_clk_o,
   output logic             pdm_o,
   output logic             underrun_o,
   output logic             busy_o
);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             pdm_clk_q, pdm_clk_d;
   logic             pdm_q, pdm_d;
   logic             ready_q, ready_d;
   logic             underrun_q, underrun_d;
   logic             armed_q, armed_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] hold_q, hold_d;

   logic             div_hit;
   logic             strobe;
   logic             xfer;
   logic [DIV_W-1:0] osr_m1;
   logic [WIDTH-1:0] u;
   logic [WIDTH:0]   sum;

   // >= keeps a live shrink of clk_div or osr from running past the terminal count
   assign div_hit = (div_cnt_q >= clk_div);
   assign strobe  = div_hit & pdm_clk_q;
   assign xfer    = pcm_valid_i & ready_q;
   assign osr_m1  = (osr == '0) ? '0 : osr - DIV_W'(1);

   // Next-state logic: divider, handshake, sample period and modulator
   always_comb begin
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      pdm_clk_d   = pdm_clk_q;
      pdm_d       = pdm_q;
      ready_d     = ready_q;
      underrun_d  = underrun_q;
      armed_d     = armed_q;
      hold_full_d = hold_full_q;
      acc_d       = acc_q;
      cur_d       = cur_q;
      hold_d      = hold_q;
      u           = '0;
      sum         = '0;

      if (!enable) begin
         div_cnt_d   = '0;
         bit_cnt_d   = '0;
         pdm_clk_d   = 1'b0;
         pdm_d       = 1'b0;
         ready_d     = 1'b0;
         underrun_d  = 1'b0;
         armed_d     = 1'b0;
         hold_full_d = 1'b0;
         acc_d       = '0;
         cur_d       = '0;
         hold_d      = '0;
      end else begin
         if (div_hit) begin
            div_cnt_d = '0;
            pdm_clk_d = ~pdm_clk_q;
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end

         // Acceptance needs ready_q, which is low whenever hold is full, so it
         // never coincides with the consuming strobe below.
         if (xfer) begin
            hold_d      = pcm_i;
            hold_full_d = 1'b1;
            armed_d     = 1'b1;
         end

         if (strobe) begin
            bit_cnt_d = (bit_cnt_q >= osr_m1) ? '0 : bit_cnt_q + DIV_W'(1);

            if (bit_cnt_q == '0) begin
               if (hold_full_q) begin
                  cur_d       = hold_q;
                  hold_full_d = 1'b0;
               end else begin
                  cur_d = '0;
                  if (armed_q) underrun_d = 1'b1;
               end
            end

            // Offset-binary via MSB flip; cur_d bypasses the freshly loaded sample
            u     = {~cur_d[WIDTH-1], cur_d[WIDTH-2:0]};
            sum   = {1'b0, acc_q} + {1'b0, u};
            pdm_d = sum[WIDTH];
            acc_d = sum[WIDTH-1:0];
         end

         // Follows hold_full_q one cycle late so ready rises a clock after consumption
         ready_d = ~hold_full_q & ~xfer;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         pdm_clk_q   <= 1'b0;
         pdm_q       <= 1'b0;
         ready_q     <= 1'b0;
         underrun_q  <= 1'b0;
         armed_q     <= 1'b0;
         hold_full_q <= 1'b0;
         acc_q       <= '0;
         cur_q       <= '0;
         hold_q      <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         pdm_clk_q   <= pdm_clk_d;
         pdm_q       <= pdm_d;
         ready_q     <= ready_d;
         underrun_q  <= underrun_d;
         armed_q     <= armed_d;
         hold_full_q <= hold_full_d;
         acc_q       <= acc_d;
         cur_q       <= cur_d;
         hold_q      <= hold_d;
      end
   end

   assign pcm_ready_o = ready_q;
   assign pdm_clk_o   = pdm_clk_q;
   assign pdm_o       = pdm_q;
   assign underrun_o  = underrun_q;
   assign busy_o      = armed_q;

endmodule
